// File: rtl/gpio_debouncer.sv
// Per-channel GPIO debouncer: two-flop synchronizer, then a level is accepted only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the current debounced level.
module gpio_debouncer #(
    parameter int                    GPIO_WIDTH      = 3,
    parameter int                    DEBOUNCE_CYCLES = 120000,
    parameter logic [GPIO_WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [GPIO_WIDTH-1:0] raw_input,
    output logic [GPIO_WIDTH-1:0] debounced,
    output logic [GPIO_WIDTH-1:0] rise_pulse,
    output logic [GPIO_WIDTH-1:0] fall_pulse,
    output logic                  any_change
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        STABLE,
        SETTLING
    } chan_state_e;

    logic [GPIO_WIDTH-1:0] sync1;
    logic [GPIO_WIDTH-1:0] sync2;
    logic [CNT_W-1:0]      count      [GPIO_WIDTH];
    logic [CNT_W-1:0]      count_next [GPIO_WIDTH];
    chan_state_e           state      [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] debounced_next;
    logic [GPIO_WIDTH-1:0] rise_next;
    logic [GPIO_WIDTH-1:0] fall_next;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; with = the
    // synchronizer would collapse into a single stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INIT_VALUE;
            sync2 <= INIT_VALUE;
        end else begin
            sync1 <= raw_input;
            sync2 <= sync1;
        end
    end

    // NOTE: every variable gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        debounced_next = debounced;
        rise_next      = '0;
        fall_next      = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            state[i]      = (sync2[i] == debounced[i]) ? STABLE : SETTLING;
            count_next[i] = '0;
            if (state[i] == SETTLING) begin
                if (count[i] == CNT_LAST) begin
                    debounced_next[i] = sync2[i];
                    rise_next[i]      = sync2[i];
                    fall_next[i]      = ~sync2[i];
                end else begin
                    count_next[i] = count[i] + CNT_ONE;
                end
            end
        end
    end

    // NOTE: the counter array is reset along with the rest, so a partial count can never
    // survive reset and fire early after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                count[i] <= '0;
            end
            debounced  <= INIT_VALUE;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                count[i] <= count_next[i];
            end
            debounced  <= debounced_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            any_change <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_gpio_debouncer.sv
// Self-checking bench: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance checked against
// a window-based reference model (accept when the last N synchronized samples all differ).
module tb_gpio_debouncer;

    localparam int W = 3;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_a   = '0;
    logic [W-1:0] raw_b   = '0;
    logic [W-1:0] deb_a, rise_a, fall_a;
    logic [W-1:0] deb_b, rise_b, fall_b;
    logic         any_a, any_b;

    int errors   = 0;
    int checks   = 0;
    int step_cnt = 0;
    int b_mode   = 0;

    always #5 clock = ~clock;

    gpio_debouncer #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(4), .INIT_VALUE(3'b000)) dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_input  (raw_a),
        .debounced  (deb_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .any_change (any_a)
    );

    gpio_debouncer #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(1), .INIT_VALUE(3'b000)) dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_input  (raw_b),
        .debounced  (deb_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .any_change (any_b)
    );

    // Reference model: index 0 of each history is the newest entry.
    int           dc_of [2] = '{4, 1};
    logic [W-1:0] raw_hist [2][16];
    logic [W-1:0] use_hist [2][16];
    int           use_len  [2];
    logic [W-1:0] m_deb  [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                raw_hist[d][k] = '0;
                use_hist[d][k] = '0;
            end
            use_len[d] = 0;
            m_deb[d]   = '0;
            m_rise[d]  = '0;
            m_fall[d]  = '0;
        end
    endtask

    task automatic model_edge(input int d, input logic [W-1:0] raw);
        logic [W-1:0] used;
        bit           differ;
        for (int k = 15; k > 0; k--) raw_hist[d][k] = raw_hist[d][k-1];
        raw_hist[d][0] = raw;
        used = raw_hist[d][2];  // level seen after two sampling stages
        for (int k = 15; k > 0; k--) use_hist[d][k] = use_hist[d][k-1];
        use_hist[d][0] = used;
        if (use_len[d] < 16) use_len[d]++;
        m_rise[d] = '0;
        m_fall[d] = '0;
        for (int ch = 0; ch < W; ch++) begin
            differ = (use_len[d] >= dc_of[d]);
            for (int k = 0; k < dc_of[d]; k++) begin
                if (use_hist[d][k][ch] == m_deb[d][ch]) differ = 1'b0;
            end
            if (differ) begin
                m_rise[d][ch] = used[ch];
                m_fall[d][ch] = ~used[ch];
                m_deb[d][ch]  = used[ch];
            end
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_cnt, observed, expected);
        end
    endtask

    task automatic check_all();
        check("a_deb",  deb_a,  m_deb[0]);
        check("a_rise", rise_a, m_rise[0]);
        check("a_fall", fall_a, m_fall[0]);
        check("a_any",  {2'b00, any_a}, {2'b00, |(m_rise[0] | m_fall[0])});
        check("a_excl", rise_a & fall_a, 3'b000);
        check("b_deb",  deb_b,  m_deb[1]);
        check("b_rise", rise_b, m_rise[1]);
        check("b_fall", fall_b, m_fall[1]);
        check("b_any",  {2'b00, any_b}, {2'b00, |(m_rise[1] | m_fall[1])});
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later, then raw_b moves.
    task automatic step();
        @(posedge clock);
        model_edge(0, raw_a);
        model_edge(1, raw_b);
        #1;
        check_all();
        step_cnt++;
        if (b_mode == 0) begin
            if (step_cnt % 4 == 0) raw_b = ~raw_b;
        end else if ($urandom_range(1) == 1) begin
            raw_b = W'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_deb_a"},  deb_a,  3'b000);
        check({tag, "_rise_a"}, rise_a, 3'b000);
        check({tag, "_fall_a"}, fall_a, 3'b000);
        check({tag, "_any_a"},  {2'b00, any_a}, 3'b000);
        check({tag, "_deb_b"},  deb_b,  3'b000);
    endtask

    initial begin
        int rise_count;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");

        // Release with a level already differing from INIT_VALUE: no pulse until 6 edges.
        @(negedge clock);
        raw_a   = 3'b011;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) check("release_no_early", rise_a, 3'b000);
            if (i == 5) check("release_rise", rise_a, 3'b011);
        end

        raw_a = 3'b111;
        repeat (8) step();
        check("all_high", deb_a, 3'b111);
        raw_a = 3'b010;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) check("fall_not_yet", deb_a, 3'b111);
            if (i == 5) check("fall_pulse", fall_a, 3'b101);
            if (i == 5) check("fall_deb", deb_a, 3'b010);
        end

        raw_a = 3'b000;
        repeat (8) step();
        raw_a = 3'b001;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 5) check("single_rise", rise_a, 3'b001);
            if (i == 6) check("single_rise_once", rise_a, 3'b000);
        end
        raw_a = 3'b000;
        repeat (8) step();

        // Bursts of 3 high cycles never reach the 4-cycle threshold.
        for (int r = 0; r < 5; r++) begin
            raw_a = 3'b010;
            repeat (3) step();
            raw_a = 3'b000;
            repeat (3) step();
        end
        check("glitch_rejected", deb_a, 3'b000);

        // Asynchronous reset in the middle of settling.
        raw_a = 3'b011;
        repeat (8) step();
        raw_a = 3'b100;
        repeat (3) step();
        check("pre_reset_deb", deb_a, 3'b011);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n    = 1'b1;
        rise_count = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rise_a[2]) rise_count++;
            if (i == 5) check("post_reset_deb", deb_a, 3'b100);
        end
        check("post_reset_one_rise", W'(rise_count), 3'b001);

        // Randomized traffic on both instances.
        b_mode = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if ($urandom_range(4) == 0) raw_a = W'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_debouncer.md
GPIO_DEBOUNCER -- requirements
Module: gpio_debouncer

Interface
REQ-001 SHALL provide parameter GPIO_WIDTH, default 3, number of independent input channels (1..32).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 120000 (10 ms at 12 MHz), consecutive disagreeing cycles required to accept a new level (>= 1).
REQ-003 SHALL provide parameter INIT_VALUE, default all zeros, GPIO_WIDTH bits, reset level of every channel's internal and output state.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port raw_input  input  GPIO_WIDTH  unsynchronized pad/button levels.
REQ-007 SHALL have port debounced  output  GPIO_WIDTH  accepted stable level per channel; feeds gpio_input or reset logic downstream.
REQ-008 SHALL have port rise_pulse  output  GPIO_WIDTH  one-cycle pulse when debounced[i] changes 0->1.
REQ-009 SHALL have port fall_pulse  output  GPIO_WIDTH  one-cycle pulse when debounced[i] changes 1->0.
REQ-010 SHALL have port any_change  output  1  OR of all rise_pulse and fall_pulse bits.

Function
REQ-011 SHALL pass each raw_input bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL keep one counter per channel, width clog2(DEBOUNCE_CYCLES+1), with no sharing between channels.
REQ-013 SHALL per channel operate in state STABLE when sync2 == debounced, and in state SETTLING otherwise.
REQ-014 SHALL in STABLE clear the counter to 0 every cycle.
REQ-015 SHALL in SETTLING increment the counter by 1 per cycle while count < DEBOUNCE_CYCLES-1.
REQ-016 SHALL, at the edge where SETTLING holds and count == DEBOUNCE_CYCLES-1, load debounced <= sync2, clear the counter, and assert the matching rise/fall pulse for exactly that following cycle.
REQ-017 SHALL on any single cycle where sync2 returns to debounced during SETTLING (glitch) clear the counter to 0 with no output change and no pulse.
REQ-018 SHALL give latency of DEBOUNCE_CYCLES+2 rising edges from a raw_input level that is stable before edge E0 to debounced changing at edge E(DEBOUNCE_CYCLES+1).
REQ-019 SHALL for DEBOUNCE_CYCLES == 1 accept a new level on the first cycle sync2 disagrees; latency is 3 edges.
REQ-020 SHALL never saturate or wrap the counter; its maximum value is DEBOUNCE_CYCLES-1.
REQ-021 SHALL keep rise_pulse[i] and fall_pulse[i] mutually exclusive and never assert either in consecutive cycles for the same channel when DEBOUNCE_CYCLES >= 2.
REQ-022 SHALL process simultaneous changes on several channels independently; any_change is asserted for one cycle if one or more channels pulse that cycle.
REQ-023 SHALL register all outputs; no combinational path from raw_input to any output.

Reset
REQ-024 SHALL, while reset_n is low, asynchronously force sync1, sync2 and debounced to INIT_VALUE, all counters to 0, and rise_pulse, fall_pulse and any_change to 0.
REQ-025 SHALL not emit a pulse on reset release even if raw_input differs from INIT_VALUE; such a difference is treated as a normal SETTLING sequence after release.
REQ-026 SHALL, on reset asserted mid-SETTLING, discard the partial count; counting restarts from 0 after release.

Verification (bench uses GPIO_WIDTH=3, DEBOUNCE_CYCLES=4, INIT_VALUE=3'b000)
REQ-027 SHALL cover: raw_input 3'b001 held from edge E0 -> debounced=3'b001 and rise_pulse=3'b001, any_change=1 for exactly one cycle after edge E5; no other change.
REQ-028 SHALL cover: raw_input[1] high for 3 cycles, then low, repeated 5 times -> debounced stays 3'b000, no pulses.
REQ-029 SHALL cover: debounced=3'b111, then raw_input=3'b010 held -> fall_pulse=3'b101 for one cycle, debounced=3'b010 after DEBOUNCE_CYCLES+2 edges.
REQ-030 SHALL cover: reset_n low asynchronously with raw_input=3'b100 after 2 SETTLING cycles -> outputs 0 immediately without a clock edge; after release, debounced=3'b100 after a full 6 edges, rise_pulse only once.
REQ-031 SHALL cover: reset_n released with raw_input=3'b011 held -> no pulse on release; rise_pulse=3'b011 one cycle after 6 edges.
REQ-032 SHALL cover: DEBOUNCE_CYCLES=1 build, raw_input toggling each 4 cycles -> each toggle is reflected 3 edges later with one matching pulse.
